band_sample_queue: RTL

BAND_SAMPLE_QUEUE -- requirements
Module: band_sample_queue

---
 rtl/band_sample_queue_pkg.sv | 20 ++
 rtl/band_sample_queue_if.sv | 31 +++
 rtl/band_sample_queue_ram.sv | 51 +++++
 rtl/band_sample_queue.sv | 136 +++++++++++++
 4 files changed

// File: rtl/band_sample_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package  : eq_pkg
// Purpose  : Shared sample width, queue geometry defaults and FSM state type.
// Revision : 1.0
// ============================================================================
package eq_pkg;

  localparam int DW            = 16;
  localparam int DEPTH_DEFAULT = 1024;
  localparam int TAPS_DEFAULT  = 1021;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEQ  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/band_sample_queue_if.sv
`default_nettype none
// ============================================================================
// Interface : band_sample_queue_if
// Purpose   : Stereo sample input and filter-side readout bundle.
// Revision  : 1.0
// ============================================================================
interface band_sample_queue_if #(
  parameter int DW = eq_pkg::DW
);

  logic                 wrt_smpl;
  logic signed [DW-1:0] lft_smpl;
  logic signed [DW-1:0] rght_smpl;
  logic                 sequencing;
  logic signed [DW-1:0] lft_out;
  logic signed [DW-1:0] rght_out;
  logic                 primed;
  logic                 ovr;

  modport master (
    output wrt_smpl, lft_smpl, rght_smpl,
    input  sequencing, lft_out, rght_out, primed, ovr
  );

  modport slave (
    input  wrt_smpl, lft_smpl, rght_smpl,
    output sequencing, lft_out, rght_out, primed, ovr
  );

endinterface
`default_nettype wire

// File: rtl/band_sample_queue_ram.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_stereo
// Purpose  : Stereo sample store, one write port, one registered read port.
// Revision : 1.0
// ============================================================================
module dp_ram_stereo #(
  parameter  int DEPTH = eq_pkg::DEPTH_DEFAULT,
  parameter  int WW    = 2 * eq_pkg::DW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire logic [WW-1:0] wdata,
  input  wire logic          re,
  input  wire logic [AW-1:0] raddr,
  output logic      [WW-1:0] rdata
);

  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rdata_q;
  logic [WW-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Output register holds its last word whenever no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/band_sample_queue.sv
`default_nettype none
// ============================================================================
// Module   : band_sample_queue
// Purpose  : Circular stereo sample history; replays the newest TAPS samples
//            oldest-first to a downstream filter after every accepted write.
// Revision : 1.0
// ============================================================================
module band_sample_queue #(
  parameter int DEPTH = eq_pkg::DEPTH_DEFAULT,
  parameter int TAPS  = eq_pkg::TAPS_DEFAULT,
  parameter int DW    = eq_pkg::DW
) (
  input wire logic           clk,
  input wire logic           rst,
  band_sample_queue_if.slave bus
);

  import eq_pkg::*;

  localparam int            AW     = $clog2(DEPTH);
  localparam int            CW     = $clog2(TAPS + 1);
  localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);
  localparam logic [CW-1:0] LAST_C = CW'(TAPS - 1);

  state_e          state_q,   state_d;
  logic [AW-1:0]   new_ptr_q, new_ptr_d;
  logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]   count_q,   count_d;
  logic [CW-1:0]   seq_cnt_q, seq_cnt_d;
  logic            ovr_q,     ovr_d;
  logic            accept;
  logic            ram_re;
  logic [2*DW-1:0] ram_rdata;

  assign accept = (state_q == IDLE) && bus.wrt_smpl;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && (count_d == TAPS_C)) state_d = ADDR;
      ADDR:    state_d = SEQ;
      SEQ:     if (seq_cnt_q == LAST_C) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ram_re         = 1'b0;
    bus.sequencing = 1'b0;
    unique case (state_q)
      ADDR:    ram_re = 1'b1;
      SEQ: begin
        bus.sequencing = 1'b1;
        ram_re         = (seq_cnt_q != LAST_C);
      end
      default: ram_re = 1'b0;
    endcase
  end

  // Pointer, fill and overrun bookkeeping
  always_comb begin
    new_ptr_d = new_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    seq_cnt_d = seq_cnt_q;
    ovr_d     = ovr_q;
    if (accept) begin
      new_ptr_d = new_ptr_q + 1'b1;
      rd_ptr_d  = new_ptr_q + 1'b1 - TAPS_A;
      if (count_q != TAPS_C) begin
        count_d = count_q + 1'b1;
      end
    end
    if (ram_re) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (state_q == ADDR) begin
      seq_cnt_d = '0;
    end else if (state_q == SEQ) begin
      seq_cnt_d = seq_cnt_q + 1'b1;
    end
    // Writes arriving while a burst is in flight are lost, never queued.
    if (bus.wrt_smpl && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_ptr_q <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      seq_cnt_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      new_ptr_q <= new_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      seq_cnt_q <= seq_cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  dp_ram_stereo #(
    .DEPTH (DEPTH),
    .WW    (2 * DW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (new_ptr_q),
    .wdata ({bus.lft_smpl, bus.rght_smpl}),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign bus.lft_out  = ram_rdata[2*DW-1:DW];
  assign bus.rght_out = ram_rdata[DW-1:0];
  assign bus.primed   = (count_q == TAPS_C);
  assign bus.ovr      = ovr_q;

endmodule
`default_nettype wire
